sram_buffer_responder: RTL and testbench

//  On-chip SRAM-style responder at the memory end of the effects buffer bus (sram_* strobes, active-low).

---
 rtl/sram_buffer_responder.sv | 152 +++++++++++++++
 tb/tb_sram_buffer_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sram_buffer_responder.sv
// sram_buffer_responder
//   SRAM-style responder at the memory end of the effects buffer bus.
//   Decodes the active-low strobes on each clk_sys edge, stores words in an
//   internal array and returns read data after RD_LAT cycles. It also keeps
//   saturating access counters and sticky protocol-error flags.
//
//   Optional feature macro: SRAM_PARITY_EN. When defined, each word carries an
//   even-parity bit. Parity is checked on read and reported in parity_err.
//
// Ports
//   clk_sys        clock, everything on the rising edge
//   rst            synchronous active-high reset
//   sram_addr      word address; only [DEPTH_LOG2-1:0] indexes memory
//   sram_wdata     write data
//   sram_ce_n/we_n/oe_n  active-low chip / write / output enables
//   sram_rdata     read data, holds its value between reads
//   sram_rvalid    one-cycle strobe per completed read
//   clear_stats    synchronous clear of counters and sticky flags
//   tst_flip_par   invert the stored parity bit on write (parity builds only)
//   stat_rd_count  reads accepted, saturating
//   stat_wr_count  writes performed, saturating
//   status_flags   {parity_err, oob_err, conflict_err, busy}
module sram_buffer_responder #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2     // legal range 1..4
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [15:0]       sram_addr,
    input  logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_ce_n,
    input  logic              sram_we_n,
    input  logic              sram_oe_n,
    output logic [DATA_W-1:0] sram_rdata,
    output logic              sram_rvalid,
    input  logic              clear_stats,
    input  logic              tst_flip_par,
    output logic [15:0]       stat_rd_count,
    output logic [15:0]       stat_wr_count,
    output logic [3:0]        status_flags
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef SRAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  oob;
    logic                  wr_req, rd_req, conflict, wr_en;
    logic [MEM_W-1:0]      mem_q;
    logic [MEM_W-1:0]      wr_word;
    logic [DATA_W-1:0]     rd_word;

    assign idx = sram_addr[DEPTH_LOG2-1:0];
    assign oob = (sram_addr >> DEPTH_LOG2) != 16'd0;

    // A write always wins over a read. If oe_n is also low, the read is
    // dropped and the cycle is flagged as a conflict.
    assign wr_req   = ~sram_ce_n & ~sram_we_n;
    assign rd_req   = ~sram_ce_n &  sram_we_n & ~sram_oe_n;
    assign conflict =  wr_req & ~sram_oe_n;
    assign wr_en    =  wr_req & ~oob & ~rst;

    assign mem_q   = mem[idx];
    assign rd_word = oob ? '0 : mem_q[DATA_W-1:0];

`ifdef SRAM_PARITY_EN
    assign wr_word = {(^sram_wdata) ^ tst_flip_par, sram_wdata};
`else
    logic unused_flip;
    assign unused_flip = tst_flip_par;
    assign wr_word     = sram_wdata;
`endif

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[idx] <= wr_word;
    end

    // Read pipeline. Stage 0 captures at the sampling edge. The last stage
    // drives the outputs. A stage's data loads only when a valid read enters
    // it, which lets sram_rdata hold its value between reads.
    logic [RD_LAT-1:0]             vld_pipe, vld_in;
    logic [RD_LAT-1:0][DATA_W-1:0] dat_pipe, dat_in;

    always_comb begin
        vld_in    = '0;
        dat_in    = '0;
        vld_in[0] = rd_req;
        dat_in[0] = rd_word;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_in[i] = vld_pipe[i-1];
            dat_in[i] = dat_pipe[i-1];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe <= vld_in;
            for (int i = 0; i < RD_LAT; i++)
                if (vld_in[i]) dat_pipe[i] <= dat_in[i];
        end
    end

    assign sram_rvalid = vld_pipe[RD_LAT-1];
    assign sram_rdata  = dat_pipe[RD_LAT-1];

    // Statistics and sticky flags. When clear_stats is high, the access in
    // the same cycle still executes but is not recorded.
    logic oob_err, conflict_err, parity_err;

    always_ff @(posedge clk_sys) begin
        if (rst || clear_stats) begin
            stat_rd_count <= '0;
            stat_wr_count <= '0;
            oob_err       <= 1'b0;
            conflict_err  <= 1'b0;
        end else begin
            if (wr_req && !oob && stat_wr_count != 16'hFFFF)
                stat_wr_count <= stat_wr_count + 16'd1;
            if (rd_req && stat_rd_count != 16'hFFFF)
                stat_rd_count <= stat_rd_count + 16'd1;
            if (conflict)
                conflict_err <= 1'b1;
            if ((wr_req || rd_req) && oob)
                oob_err <= 1'b1;
        end
    end

`ifdef SRAM_PARITY_EN
    logic par_bad;
    assign par_bad = rd_req & ~oob & ((^mem_q[DATA_W-1:0]) ^ mem_q[DATA_W]);

    always_ff @(posedge clk_sys) begin
        if (rst || clear_stats) parity_err <= 1'b0;
        else if (par_bad)       parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign status_flags = {parity_err, oob_err, conflict_err, |vld_pipe};

endmodule

// File: tb/tb_sram_buffer_responder.sv
module tb_sram_buffer_responder;

    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 10;
    localparam int RD_LAT     = 2;

    logic              clk_sys = 1'b0;
    logic              rst;
    logic [15:0]       sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_ce_n, sram_we_n, sram_oe_n;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_rvalid;
    logic              clear_stats, tst_flip_par;
    logic [15:0]       stat_rd_count, stat_wr_count;
    logic [3:0]        status_flags;

    sram_buffer_responder #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT)) dut (
        .clk_sys(clk_sys), .rst(rst), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid), .clear_stats(clear_stats),
        .tst_flip_par(tst_flip_par), .stat_rd_count(stat_rd_count),
        .stat_wr_count(stat_wr_count), .status_flags(status_flags)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model: a sparse word store plus a queue of outstanding reads,
    // each tagged with the edge number at which it must appear.
    typedef struct { int due; logic [31:0] d; } rd_t;
    logic [31:0] mem_m [int];
    bit          par_m [int];
    rd_t         pend [$];
    int          edge_n = 0;
    int          rd_cnt = 0, wr_cnt = 0;
    bit          f_oob = 0, f_conf = 0, f_par = 0;
    logic [31:0] last_rd = '0;
    int          checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit ce_n, input bit we_n, input bit oe_n,
                        input logic [15:0] a, input logic [31:0] d,
                        input bit clr, input bit r, input bit flip, input bit chk);
        bit is_wr, is_rd, is_oob, exp_busy, exp_v;
        sram_ce_n = ce_n; sram_we_n = we_n; sram_oe_n = oe_n;
        sram_addr = a; sram_wdata = d; clear_stats = clr; rst = r; tst_flip_par = flip;
        @(posedge clk_sys);
        edge_n++;
        if (r) begin
            pend.delete();
            rd_cnt = 0; wr_cnt = 0; f_oob = 0; f_conf = 0; f_par = 0; last_rd = '0;
        end else begin
            is_oob = (a >= 16'd1024);
            is_wr  = !ce_n && !we_n;
            is_rd  = !ce_n && we_n && !oe_n;
            if (is_wr && !is_oob) begin mem_m[a] = d; par_m[a] = flip; end
            if (is_rd) begin
                rd_t e;
                e.due = edge_n + RD_LAT - 1;
                e.d   = is_oob ? 32'h0 : mem_m[a];
                pend.push_back(e);
            end
            if (clr) begin
                rd_cnt = 0; wr_cnt = 0; f_oob = 0; f_conf = 0; f_par = 0;
            end else begin
                if (is_wr && !is_oob && wr_cnt < 65535) wr_cnt++;
                if (is_rd && rd_cnt < 65535) rd_cnt++;
                if (is_wr && !oe_n) f_conf = 1;
                if ((is_wr || is_rd) && is_oob) f_oob = 1;
`ifdef SRAM_PARITY_EN
                if (is_rd && !is_oob && par_m[a]) f_par = 1;
`endif
            end
        end
        exp_busy = pend.size() > 0;
        exp_v    = 0;
        if (exp_busy && pend[0].due == edge_n) begin
            exp_v   = 1;
            last_rd = pend[0].d;
            void'(pend.pop_front());
        end
        @(negedge clk_sys);
        if (chk) begin
            check("rvalid", {31'd0, sram_rvalid}, {31'd0, exp_v});
            check("rdata", sram_rdata, last_rd);
            check("rd_count", {16'd0, stat_rd_count}, rd_cnt);
            check("wr_count", {16'd0, stat_wr_count}, wr_cnt);
            check("flags", {28'd0, status_flags}, {28'd0, f_par, f_oob, f_conf, exp_busy});
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        step(0, 0, 1, a, d, 0, 0, 0, 1);
    endtask
    task automatic rd(input logic [15:0] a);
        step(0, 1, 0, a, 32'h0, 0, 0, 0, 1);
    endtask
    task automatic idle();
        step(1, 1, 1, 16'h0, 32'h0, 0, 0, 0, 1);
    endtask

    initial begin
        // reset state
        step(1, 1, 1, 16'h0, 32'h0, 0, 1, 0, 1);
        step(1, 1, 1, 16'h0, 32'h0, 0, 1, 0, 1);
        idle();

        // basic write then read-after-write
        wr(16'h0005, 32'hDEADBEEF);
        rd(16'h0005);
        repeat (3) idle();

        // fill 0..7 with addr*3, then back-to-back reads
        for (int i = 0; i < 8; i++) wr(i[15:0], i * 3);
        for (int i = 0; i < 8; i++) rd(i[15:0]);
        repeat (3) idle();

        // write/read conflict
        step(0, 0, 0, 16'h0010, 32'h1234, 0, 0, 0, 1);
        idle();
        rd(16'h0010);
        repeat (2) idle();

        // out-of-range write and read
        wr(16'h0400, 32'hCAFEF00D);
        rd(16'h0400);
        repeat (2) idle();

        // clear_stats alongside a write: the write lands but is not counted
        step(0, 0, 1, 16'h0020, 32'h5A5A5A5A, 1, 0, 0, 1);
        rd(16'h0020);
        repeat (2) idle();

        // randomized traffic over a pre-filled window
        for (int i = 0; i < 64; i++) wr(i[15:0], $urandom);
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [15:0] a;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0400) : 16'($urandom_range(0, 63));
            case (op)
                0, 1, 2, 3: step(0, 0, 1, a, $urandom, $urandom_range(0, 29) == 0, 0, 0, 1);
                4, 5, 6, 7: step(0, 1, 0, a, $urandom, $urandom_range(0, 29) == 0, 0, 0, 1);
                8:          step(0, 0, 0, a, $urandom, 0, 0, 0, 1);
                default:    step($urandom_range(0, 1) == 1, 1, 1, a, $urandom, 0, 0, 0, 1);
            endcase
        end
        repeat (3) idle();

        // reset while a read is in flight
        rd(16'h0005);
        step(1, 1, 1, 16'h0, 32'h0, 0, 1, 0, 1);
        repeat (3) idle();

        // write counter saturation
        for (int i = 0; i < 65540; i++) step(0, 0, 1, 16'(i % 64), i, 0, 0, 0, 0);
        idle();
        rd(16'h0003);
        repeat (2) idle();

`ifdef SRAM_PARITY_EN
        // corrupted parity is flagged but data is still returned
        step(0, 0, 1, 16'h0030, 32'h0F0F1234, 0, 0, 1, 1);
        rd(16'h0030);
        repeat (2) idle();
        step(1, 1, 1, 16'h0, 32'h0, 1, 0, 0, 1);
        idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
